// File: rtl/i2c_mon_pkg.sv
// ---------------------------------------------------------------------------
// i2c_mon_pkg
// Shared types and constants for the passive I2C target-side bus monitor.
//   i2c_mon_state_e : protocol-tracking FSM states
//   I2cAddrWidth    : 7-bit target address width
//   I2cBitsPerByte  : bits per byte on the wire (ACK bit excluded)
// ---------------------------------------------------------------------------
package i2c_mon_pkg;

  localparam int I2cAddrWidth   = 7;
  localparam int I2cBitsPerByte = 8;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    WAIT_STOP
  } i2c_mon_state_e;

endpackage

// File: rtl/i2c_mon_filter.sv
// ---------------------------------------------------------------------------
// i2c_mon_filter
// Single-bit stability filter. The output follows the input only after the
// input has disagreed with the output for GlitchCycles consecutive cycles.
// Resets to 1 (idle I2C line level).
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   in_i   : raw (already synchronised) input
//   out_o  : filtered output
// ---------------------------------------------------------------------------
module i2c_mon_filter #(
  parameter int GlitchCycles = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in_i,
  output logic out_o
);

  localparam int CntWidth = (GlitchCycles > 1) ? $clog2(GlitchCycles + 1) : 1;

  logic                r_out;
  logic [CntWidth-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_out <= 1'b1;
      r_cnt <= '0;
    end else if (in_i != r_out) begin
      // The current cycle is the (r_cnt+1)-th consecutive disagreeing sample.
      if (r_cnt == CntWidth'(GlitchCycles - 1)) begin
        r_out <= in_i;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign out_o = r_out;

endmodule

// File: rtl/i2c_target_bus_monitor.sv
// ---------------------------------------------------------------------------
// i2c_target_bus_monitor
// Passive I2C target-side bus observer. Samples SCL/SDA only (never drives
// the bus) and reports bus conditions, the received address byte with RnW,
// per-channel address/mask matches, host NACK on reads, a saturating data
// byte counter and bus-busy / bus-free status.
//
// Optional build macro: I2C_MON_GLITCH_FILTER_EN
//   defined   : SCL and SDA pass through i2c_mon_filter (GlitchCycles latency)
//   undefined : raw SCL/SDA are used; GlitchCycles is ignored
//
// Ports:
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   scl_i, sda_i       : bus lines, already synchronised to clk_i
//   enable_i           : monitor enable (0 forces IDLE, clears held outputs)
//   target_addr_i      : NumAddr x 7-bit addresses, channel k at [7k+6:7k]
//   target_mask_i      : NumAddr x 7-bit compare masks, 1 = bit compared
//   t_bus_free_i       : bus-free time in clk cycles
//   bus_start_o        : START pulse
//   bus_rstart_o       : repeated-START pulse
//   bus_stop_o         : STOP pulse
//   bus_addr_o         : {addr[6:0], RnW} of last address byte
//   bus_addr_valid_o   : pulse when bus_addr_o updates
//   addr_match_o       : per-channel match vector, held until next START
//   addr_match_idx_o   : lowest matching channel, 0 if none
//   tx_host_nack_o     : pulse when host NACKs a read byte
//   byte_cnt_o         : saturating data byte count of current transfer
//   bus_busy_o         : high from START until STOP
//   bus_free_o         : high once bus has been idle t_bus_free_i cycles
// ---------------------------------------------------------------------------
module i2c_target_bus_monitor
  import i2c_mon_pkg::*;
#(
  parameter int NumAddr      = 2,
  parameter int ByteCntWidth = 8,
  parameter int TimerWidth   = 20,
  parameter int GlitchCycles = 2,
  localparam int IdxWidth    = (NumAddr > 1) ? $clog2(NumAddr) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          scl_i,
  input  logic                          sda_i,
  input  logic                          enable_i,
  input  logic [NumAddr*I2cAddrWidth-1:0] target_addr_i,
  input  logic [NumAddr*I2cAddrWidth-1:0] target_mask_i,
  input  logic [TimerWidth-1:0]         t_bus_free_i,
  output logic                          bus_start_o,
  output logic                          bus_rstart_o,
  output logic                          bus_stop_o,
  output logic [I2cBitsPerByte-1:0]     bus_addr_o,
  output logic                          bus_addr_valid_o,
  output logic [NumAddr-1:0]            addr_match_o,
  output logic [IdxWidth-1:0]           addr_match_idx_o,
  output logic                          tx_host_nack_o,
  output logic [ByteCntWidth-1:0]       byte_cnt_o,
  output logic                          bus_busy_o,
  output logic                          bus_free_o
);

  function automatic logic [ByteCntWidth-1:0] sat_inc_cnt(input logic [ByteCntWidth-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [TimerWidth-1:0] sat_inc_tmr(input logic [TimerWidth-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic w_scl;
  logic w_sda;

`ifdef I2C_MON_GLITCH_FILTER_EN
  i2c_mon_filter #(.GlitchCycles(GlitchCycles)) u_scl_filter (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .in_i  (scl_i),
    .out_o (w_scl)
  );
  i2c_mon_filter #(.GlitchCycles(GlitchCycles)) u_sda_filter (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .in_i  (sda_i),
    .out_o (w_sda)
  );
`else
  assign w_scl = scl_i;
  assign w_sda = sda_i;
  logic w_unused_glitch;
  assign w_unused_glitch = (GlitchCycles != 0);
`endif

  // Previous-sample registers for edge detection; idle bus level is 1.
  logic r_scl_q;
  logic r_sda_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_scl_q <= 1'b1;
      r_sda_q <= 1'b1;
    end else begin
      r_scl_q <= w_scl;
      r_sda_q <= w_sda;
    end
  end

  logic w_start;
  logic w_stop;
  logic w_scl_rise;

  assign w_start    = r_scl_q & w_scl &  r_sda_q & ~w_sda;
  assign w_stop     = r_scl_q & w_scl & ~r_sda_q &  w_sda;
  assign w_scl_rise = ~r_scl_q & w_scl;

  // FSM and registered outputs
  i2c_mon_state_e               r_state;
  logic [2:0]                   r_bit_cnt;
  logic [I2cAddrWidth-1:0]      r_shift;
  logic                         r_start;
  logic                         r_rstart;
  logic                         r_stop;
  logic [I2cBitsPerByte-1:0]    r_bus_addr;
  logic                         r_addr_valid;
  logic [NumAddr-1:0]           r_match;
  logic                         r_nack;
  logic [ByteCntWidth-1:0]      r_byte_cnt;
  logic                         r_busy;

  // r_shift holds the 7 address bits by the time the RnW bit is sampled.
  logic [NumAddr-1:0] w_match;
  always_comb begin
    w_match = '0;
    for (int k = 0; k < NumAddr; k++) begin
      w_match[k] = ((r_shift & target_mask_i[k*I2cAddrWidth +: I2cAddrWidth]) ==
                    (target_addr_i[k*I2cAddrWidth +: I2cAddrWidth] &
                     target_mask_i[k*I2cAddrWidth +: I2cAddrWidth]));
    end
  end

  logic w_last_bit;
  assign w_last_bit = (r_bit_cnt == 3'(I2cBitsPerByte - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_start      <= 1'b0;
      r_rstart     <= 1'b0;
      r_stop       <= 1'b0;
      r_bus_addr   <= '0;
      r_addr_valid <= 1'b0;
      r_match      <= '0;
      r_nack       <= 1'b0;
      r_byte_cnt   <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_start      <= 1'b0;
      r_rstart     <= 1'b0;
      r_stop       <= 1'b0;
      r_addr_valid <= 1'b0;
      r_nack       <= 1'b0;

      if (!enable_i) begin
        r_state    <= IDLE;
        r_bit_cnt  <= '0;
        r_shift    <= '0;
        r_bus_addr <= '0;
        r_match    <= '0;
        r_byte_cnt <= '0;
        r_busy     <= 1'b0;
      end else if (w_start) begin
        // Bus conditions win over bit sampling in the same cycle.
        if (r_busy) r_rstart <= 1'b1;
        else        r_start  <= 1'b1;
        r_busy     <= 1'b1;
        r_state    <= ADDR;
        r_bit_cnt  <= '0;
        r_match    <= '0;
        r_byte_cnt <= '0;
      end else if (w_stop) begin
        r_stop  <= 1'b1;
        r_busy  <= 1'b0;
        r_state <= IDLE;
      end else if (w_scl_rise) begin
        case (r_state)
          ADDR: begin
            r_shift <= {r_shift[I2cAddrWidth-2:0], w_sda};
            if (w_last_bit) begin
              r_bit_cnt    <= '0;
              r_bus_addr   <= {r_shift, w_sda};
              r_addr_valid <= 1'b1;
              r_match      <= w_match;
              r_state      <= ADDR_ACK;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
          ADDR_ACK: begin
            if (!w_sda && (|r_match)) r_state <= r_bus_addr[0] ? RD_BYTE : WR_BYTE;
            else                      r_state <= WAIT_STOP;
          end
          WR_BYTE, RD_BYTE: begin
            if (w_last_bit) begin
              r_bit_cnt <= '0;
              r_state   <= (r_state == WR_BYTE) ? WR_ACK : RD_ACK;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
          WR_ACK: begin
            r_byte_cnt <= sat_inc_cnt(r_byte_cnt);
            r_state    <= w_sda ? WAIT_STOP : WR_BYTE;
          end
          RD_ACK: begin
            r_byte_cnt <= sat_inc_cnt(r_byte_cnt);
            if (w_sda) begin
              r_nack  <= 1'b1;
              r_state <= WAIT_STOP;
            end else begin
              r_state <= RD_BYTE;
            end
          end
          default: ;  // IDLE, WAIT_STOP: bits ignored
        endcase
      end
    end
  end

  // Bus-free timer: runs regardless of enable_i. It counts while the bus is
  // idle-high in IDLE, including the STOP cycle itself so that a zero
  // threshold asserts bus_free_o together with the STOP pulse.
  logic [TimerWidth-1:0] r_timer;
  logic                  r_free;
  logic                  w_timer_run;

  assign w_timer_run = ((r_state == IDLE) || w_stop) && w_scl && w_sda;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_timer <= '0;
      r_free  <= 1'b1;
    end else if (w_start) begin
      r_timer <= '0;
      r_free  <= 1'b0;
    end else if (w_timer_run) begin
      r_timer <= sat_inc_tmr(r_timer);
      if (r_timer >= t_bus_free_i) r_free <= 1'b1;
    end
  end

  // Lowest set bit wins: scan from the top so the lowest index is written last.
  logic [IdxWidth-1:0] w_match_idx;
  always_comb begin
    w_match_idx = '0;
    for (int k = NumAddr - 1; k >= 0; k--) begin
      if (r_match[k]) w_match_idx = IdxWidth'(k);
    end
  end

  assign bus_start_o      = r_start;
  assign bus_rstart_o     = r_rstart;
  assign bus_stop_o       = r_stop;
  assign bus_addr_o       = r_bus_addr;
  assign bus_addr_valid_o = r_addr_valid;
  assign addr_match_o     = r_match;
  assign addr_match_idx_o = w_match_idx;
  assign tx_host_nack_o   = r_nack;
  assign byte_cnt_o       = r_byte_cnt;
  assign bus_busy_o       = r_busy;
  assign bus_free_o       = r_free;

endmodule

// File: tb/tb_i2c_target_bus_monitor.sv
// ---------------------------------------------------------------------------
// tb_i2c_target_bus_monitor
// Table-driven transfers with an address scoreboard, plus hand-written
// sequences for repeated START, enable drop, async reset and SDA glitch.
// ---------------------------------------------------------------------------
module tb_i2c_target_bus_monitor;

  localparam int H = 3;  // clk cycles per I2C phase

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scl;
  logic        sda;
  logic        en;
  logic [13:0] tgt_addr;
  logic [13:0] tgt_mask;
  logic [19:0] tbf;

  logic        bus_start_o;
  logic        bus_rstart_o;
  logic        bus_stop_o;
  logic [7:0]  bus_addr_o;
  logic        bus_addr_valid_o;
  logic [1:0]  addr_match_o;
  logic [0:0]  addr_match_idx_o;
  logic        tx_host_nack_o;
  logic [7:0]  byte_cnt_o;
  logic        bus_busy_o;
  logic        bus_free_o;

  i2c_target_bus_monitor dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .scl_i           (scl),
    .sda_i           (sda),
    .enable_i        (en),
    .target_addr_i   (tgt_addr),
    .target_mask_i   (tgt_mask),
    .t_bus_free_i    (tbf),
    .bus_start_o     (bus_start_o),
    .bus_rstart_o    (bus_rstart_o),
    .bus_stop_o      (bus_stop_o),
    .bus_addr_o      (bus_addr_o),
    .bus_addr_valid_o(bus_addr_valid_o),
    .addr_match_o    (addr_match_o),
    .addr_match_idx_o(addr_match_idx_o),
    .tx_host_nack_o  (tx_host_nack_o),
    .byte_cnt_o      (byte_cnt_o),
    .bus_busy_o      (bus_busy_o),
    .bus_free_o      (bus_free_o)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Output monitor: sampled on the falling edge.
  int         cyc        = 0;
  int         n_start    = 0;
  int         n_rstart   = 0;
  int         n_stop     = 0;
  int         n_nack     = 0;
  int         n_valid    = 0;
  int         n_busyfall = 0;
  int         stop_cyc   = 0;
  int         free_cyc   = 0;
  logic       prev_free  = 1'b1;
  logic       prev_busy  = 1'b0;
  logic [7:0] cap_mem [0:63];
  int         cap_wr     = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus_start_o)    n_start  <= n_start + 1;
    if (bus_rstart_o)   n_rstart <= n_rstart + 1;
    if (bus_stop_o)     begin n_stop <= n_stop + 1; stop_cyc <= cyc; end
    if (tx_host_nack_o) n_nack   <= n_nack + 1;
    if (bus_addr_valid_o) begin
      cap_mem[cap_wr % 64] <= bus_addr_o;
      cap_wr  <= cap_wr + 1;
      n_valid <= n_valid + 1;
    end
    if (bus_free_o && !prev_free) free_cyc <= cyc;
    if (prev_busy && !bus_busy_o) n_busyfall <= n_busyfall + 1;
    prev_free <= bus_free_o;
    prev_busy <= bus_busy_o;
  end

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Address scoreboard: expected bytes pushed as the address is driven.
  logic [7:0] exp_q[$];
  int         cap_rd = 0;

  task automatic drain_scoreboard();
    logic [7:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("bus_addr", (cap_rd < cap_wr) ? {24'h0, cap_mem[cap_rd % 64]} : 32'hDEAD, {24'h0, e});
      cap_rd++;
    end
    check("addr_extra", cap_wr, cap_rd);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sbit(input logic b);
    sda = b;  tick(H);
    scl = 1'b1; tick(H);
    scl = 1'b0; tick(H);
  endtask

  task automatic sbyte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) sbit(b[i]);
  endtask

  task automatic sstart();
    sda = 1'b1; tick(H);
    scl = 1'b1; tick(H);
    sda = 1'b0; tick(H);
    scl = 1'b0; tick(H);
  endtask

  task automatic sstop();
    sda = 1'b0; tick(H);
    scl = 1'b1; tick(H);
    sda = 1'b1; tick(H);
  endtask

  typedef struct {
    logic [6:0]  addr7;
    logic        rnw;
    int          nbytes;
    logic        nack_last;
    logic [13:0] ch_addr;
    logic [13:0] ch_mask;
    logic [19:0] tbf;
    logic [7:0]  exp_addr;
    logic [1:0]  exp_match;
    logic        exp_idx;
    logic [7:0]  exp_cnt;
    int          exp_nack;
    int          exp_free_dly;
  } vec_t;

  vec_t vecs [6];

  task automatic run_xfer(input vec_t v);
    int s_start, s_rstart, s_stop, s_nack;
    tgt_addr = v.ch_addr;
    tgt_mask = v.ch_mask;
    tbf      = v.tbf;
    tick(2);
    s_start = n_start; s_rstart = n_rstart; s_stop = n_stop; s_nack = n_nack;
    sstart();
    exp_q.push_back(v.exp_addr);
    sbyte({v.addr7, v.rnw});
    sbit(v.exp_match == 2'b00);
    check("addr_match", addr_match_o, v.exp_match);
    check("match_idx", addr_match_idx_o, v.exp_idx);
    for (int i = 0; i < v.nbytes; i++) begin
      sbyte(8'($urandom));
      sbit((i == v.nbytes - 1) ? v.nack_last : 1'b0);
    end
    check("byte_cnt", byte_cnt_o, v.exp_cnt);
    check("busy_mid", bus_busy_o, 1'b1);
    check("free_mid", bus_free_o, 1'b0);
    sstop();
    tick(int'(v.tbf) + 10);
    check("start_cnt", n_start - s_start, 1);
    check("rstart_cnt", n_rstart - s_rstart, 0);
    check("stop_cnt", n_stop - s_stop, 1);
    check("nack_cnt", n_nack - s_nack, v.exp_nack);
    check("busy_end", bus_busy_o, 1'b0);
    check("free_end", bus_free_o, 1'b1);
    check("free_delay", free_cyc - stop_cyc, v.exp_free_dly);
    drain_scoreboard();
  endtask

  int s_start, s_rstart, s_stop, s_nack, s_valid, s_fall;

  initial begin
    vecs[0] = '{7'h0C, 1'b0, 2,   1'b0, {7'h28, 7'h0C}, {7'h7C, 7'h7F}, 20'd50, 8'h18, 2'b01, 1'b0, 8'd2,   0, 50};
    vecs[1] = '{7'h2A, 1'b1, 3,   1'b1, {7'h28, 7'h0C}, {7'h7C, 7'h7F}, 20'd50, 8'h55, 2'b10, 1'b1, 8'd3,   1, 50};
    vecs[2] = '{7'h55, 1'b1, 2,   1'b1, {7'h28, 7'h0C}, {7'h7C, 7'h7F}, 20'd50, 8'hAB, 2'b00, 1'b0, 8'd0,   0, 50};
    vecs[3] = '{7'h28, 1'b0, 1,   1'b0, {7'h28, 7'h28}, {7'h7C, 7'h7F}, 20'd0,  8'h50, 2'b11, 1'b0, 8'd1,   0, 0};
    vecs[4] = '{7'h0D, 1'b0, 257, 1'b0, {7'h28, 7'h0C}, {7'h7C, 7'h7E}, 20'd5,  8'h1A, 2'b01, 1'b0, 8'd255, 0, 5};
    vecs[5] = '{7'h2B, 1'b0, 1,   1'b0, {7'h28, 7'h0C}, {7'h7C, 7'h7F}, 20'd1,  8'h56, 2'b10, 1'b1, 8'd1,   0, 1};

    rst_n = 1'b0; scl = 1'b1; sda = 1'b1; en = 1'b1;
    tgt_addr = '0; tgt_mask = '0; tbf = 20'd50;
    tick(3);
    check("rst_start", bus_start_o, 1'b0);
    check("rst_addr", bus_addr_o, 8'h00);
    check("rst_match", addr_match_o, 2'b00);
    check("rst_cnt", byte_cnt_o, 8'h00);
    check("rst_busy", bus_busy_o, 1'b0);
    check("rst_free", bus_free_o, 1'b1);
    rst_n = 1'b1;
    tick(3);
    check("post_rst_free", bus_free_o, 1'b1);

    for (int i = 0; i < 6; i++) run_xfer(vecs[i]);

    // Write then repeated START and read from the same target.
    tgt_addr = {7'h28, 7'h0C}; tgt_mask = {7'h7C, 7'h7F}; tbf = 20'd50;
    tick(2);
    s_start = n_start; s_rstart = n_rstart; s_stop = n_stop; s_nack = n_nack;
    sstart();
    exp_q.push_back(8'h18);
    sbyte(8'h18); sbit(1'b0);
    sbyte(8'hA5); sbit(1'b0);
    check("rs_cnt1", byte_cnt_o, 8'd1);
    s_fall = n_busyfall;
    sstart();
    check("rs_rstart", n_rstart - s_rstart, 1);
    check("rs_start", n_start - s_start, 1);
    check("rs_busy", bus_busy_o, 1'b1);
    check("rs_cnt_clr", byte_cnt_o, 8'd0);
    exp_q.push_back(8'h19);
    sbyte(8'h19); sbit(1'b0);
    sbyte(8'h3C); sbit(1'b1);
    check("rs_nack", n_nack - s_nack, 1);
    check("rs_cnt2", byte_cnt_o, 8'd1);
    check("rs_nofall", n_busyfall - s_fall, 0);
    sstop();
    tick(60);
    check("rs_stop", n_stop - s_stop, 1);
    drain_scoreboard();

    // enable_i dropped mid-byte.
    tick(2);
    sstart();
    exp_q.push_back(8'h18);
    sbyte(8'h18); sbit(1'b0);
    sbit(1'b1); sbit(1'b0); sbit(1'b1);
    en = 1'b0;
    tick(2);
    check("dis_busy", bus_busy_o, 1'b0);
    check("dis_match", addr_match_o, 2'b00);
    check("dis_addr", bus_addr_o, 8'h00);
    check("dis_cnt", byte_cnt_o, 8'h00);
    s_start = n_start; s_rstart = n_rstart; s_stop = n_stop; s_nack = n_nack; s_valid = n_valid;
    for (int i = 0; i < 5; i++) sbit(1'b0);
    sbit(1'b1);
    sstop();
    tick(10);
    check("dis_pulses", (n_start - s_start) + (n_rstart - s_rstart) + (n_stop - s_stop) +
                        (n_nack - s_nack) + (n_valid - s_valid), 0);
    en = 1'b1;
    tick(5);
    drain_scoreboard();
    run_xfer(vecs[0]);

    // Asynchronous reset mid-byte.
    tick(2);
    sstart();
    exp_q.push_back(8'h18);
    sbyte(8'h18); sbit(1'b0);
    sbit(1'b0); sbit(1'b1); sbit(1'b1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy", bus_busy_o, 1'b0);
    check("arst_match", addr_match_o, 2'b00);
    check("arst_addr", bus_addr_o, 8'h00);
    check("arst_cnt", byte_cnt_o, 8'h00);
    check("arst_free", bus_free_o, 1'b1);
    s_start = n_start; s_rstart = n_rstart; s_stop = n_stop; s_nack = n_nack; s_valid = n_valid;
    sbit(1'b0); sbit(1'b1); sbit(1'b0);
    scl = 1'b1; sda = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(10);
    check("arst_pulses", (n_start - s_start) + (n_rstart - s_rstart) + (n_stop - s_stop) +
                         (n_nack - s_nack) + (n_valid - s_valid), 0);
    drain_scoreboard();
    run_xfer(vecs[1]);

    // One-cycle SDA low while SCL high.
    scl = 1'b1; sda = 1'b1;
    tick(20);
    s_start = n_start; s_stop = n_stop;
    sda = 1'b0; tick(1);
    sda = 1'b1; tick(20);
`ifdef I2C_MON_GLITCH_FILTER_EN
    check("glitch_start", n_start - s_start, 0);
    check("glitch_stop", n_stop - s_stop, 0);
`else
    check("glitch_start", n_start - s_start, 1);
    check("glitch_stop", n_stop - s_stop, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
